zprize_mul_pipe_hs: RTL and testbench

//   Limb-serial pipelined big-integer multiplier with valid/ready handshake, global-stall backpressure,
//   per-transaction output mode (full/low/high half) and metadata passthrough. Next-generation MSM

---
 rtl/zprize_mul_pipe_hs_if.sv | 30 +++
 rtl/zprize_mul_pipe_hs.sv | 118 +++++++++++
 tb/tb_zprize_mul_pipe_hs.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/zprize_mul_pipe_hs_if.sv
// Valid/ready bus for the limb-serial multiplier: operand/metadata input side and result output side.
interface zprize_mul_pipe_hs_if #(
    parameter int unsigned W0 = 384,
    parameter int unsigned W1 = 384,
    parameter int unsigned M  = 32
);
    localparam int unsigned WP = W0 + W1;

    logic            in_valid;
    logic            in_ready;
    logic [W0-1:0]   in0;
    logic [W1-1:0]   in1;
    logic [1:0]      mode;
    logic [M-1:0]    m_i;
    logic            out_valid;
    logic            out_ready;
    logic [WP-1:0]   out0;
    logic [M-1:0]    m_o;
    logic            err;

    modport master (
        output in_valid, in0, in1, mode, m_i, out_ready,
        input  in_ready, out_valid, out0, m_o, err
    );

    modport slave (
        input  in_valid, in0, in1, mode, m_i, out_ready,
        output in_ready, out_valid, out0, m_o, err
    );
endinterface

// File: rtl/zprize_mul_pipe_hs.sv
// Limb-serial pipelined big-integer multiplier: one in1 limb per stage, global stall on output backpressure,
// FULL/LO/HI output formatting and metadata carried in lockstep with each product.
module zprize_mul_pipe_hs #(
    parameter int unsigned W0   = 384,
    parameter int unsigned W1   = 384,
    parameter int unsigned LIMB = 64,
    parameter int unsigned M    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    zprize_mul_pipe_hs_if.slave  bus
);
    localparam int unsigned NL  = (W1 + LIMB - 1) / LIMB;
    localparam int unsigned W1P = NL * LIMB;
    localparam int unsigned WP  = W0 + W1;
    localparam int unsigned WH  = WP / 2;

    typedef enum logic [1:0] {
        MODE_FULL = 2'b00,
        MODE_LO   = 2'b01,
        MODE_HI   = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    // Stage 0 holds raw operands; stage k (1..NL) holds the sum of the first k partial products.
    logic [W0-1:0]  in0_q  [0:NL-1];
    logic [W1P-1:0] in1_q  [0:NL-1];
    mode_e          mode_q [0:NL];
    logic [M-1:0]   m_q    [0:NL];
    logic [WP-1:0]  acc_q  [1:NL];
    logic [WP-1:0]  acc_in [1:NL];
    logic [WP-1:0]  acc_d  [1:NL];
    logic [NL:0]    v_q;

    logic           out_valid_q;
    logic [WP-1:0]  out0_q;
    logic [WP-1:0]  out0_d;
    logic [M-1:0]   m_o_q;
    logic           err_q;

    logic           adv_c;
    logic           in_ready_c;
    logic           accept_c;

    assign adv_c      = bus.out_ready | ~out_valid_q;
    assign in_ready_c = adv_c & ~rst;
    assign accept_c   = bus.in_valid & in_ready_c;

    // Partial-product accumulation; product of W0 x LIMB bits always fits in WP, so no truncation.
    always_comb begin
        acc_in[1] = '0;
        for (int unsigned k = 2; k <= NL; k++) begin
            acc_in[k] = acc_q[k-1];
        end
        for (int unsigned k = 1; k <= NL; k++) begin
            acc_d[k] = acc_in[k]
                     + ((WP'(in0_q[k-1]) * WP'(in1_q[k-1][LIMB*(k-1) +: LIMB])) << (LIMB*(k-1)));
        end
    end

    always_comb begin
        out0_d = acc_q[NL];
        case (mode_q[NL])
            MODE_LO:  out0_d = WP'(acc_q[NL][WH-1:0]);
            MODE_HI:  out0_d = WP'(acc_q[NL][WP-1:WH]);
            default:  out0_d = acc_q[NL];
        endcase
    end

    // Control state: valids, output register and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q         <= '0;
            out_valid_q <= 1'b0;
            out0_q      <= '0;
            m_o_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            if (adv_c) begin
                v_q         <= {v_q[NL-1:0], accept_c};
                out_valid_q <= v_q[NL];
                if (v_q[NL]) begin
                    out0_q <= out0_d;
                    m_o_q  <= m_q[NL];
                end
            end
            if (accept_c && (mode_e'(bus.mode) == MODE_RSVD)) begin
                err_q <= 1'b1;
            end
        end
    end

    // Datapath shifts whenever the pipe advances; contents of invalid stages are don't-care.
    always_ff @(posedge clk) begin
        if (adv_c) begin
            in0_q[0]  <= bus.in0;
            in1_q[0]  <= W1P'(bus.in1);
            mode_q[0] <= mode_e'(bus.mode);
            m_q[0]    <= bus.m_i;
            for (int unsigned k = 1; k < NL; k++) begin
                in0_q[k] <= in0_q[k-1];
                in1_q[k] <= in1_q[k-1];
            end
            for (int unsigned k = 1; k <= NL; k++) begin
                mode_q[k] <= mode_q[k-1];
                m_q[k]    <= m_q[k-1];
                acc_q[k]  <= acc_d[k];
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out0      = out0_q;
    assign bus.m_o       = m_o_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_zprize_mul_pipe_hs.sv
// Directed and random-stream checks of zprize_mul_pipe_hs at default parameters.
module tb_zprize_mul_pipe_hs;
    localparam int unsigned W0 = 384;
    localparam int unsigned W1 = 384;
    localparam int unsigned M  = 32;
    localparam int unsigned WP = W0 + W1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    zprize_mul_pipe_hs_if #(.W0(W0), .W1(W1), .M(M)) bus ();

    zprize_mul_pipe_hs #(.W0(W0), .W1(W1), .LIMB(64), .M(M)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W0-1:0] rand_op();
        logic [W0-1:0] r;
        for (int i = 0; i < 12; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [WP-1:0] golden(input logic [W0-1:0] a, input logic [W1-1:0] b,
                                             input logic [1:0] md);
        logic [WP-1:0] p;
        p = WP'(a) * WP'(b);
        case (md)
            2'b01:   return WP'(p[WP/2-1:0]);
            2'b10:   return WP'(p[WP-1:WP/2]);
            default: return p;
        endcase
    endfunction

    // Issue one op on an empty pipe with out_ready high; report first result and edges after accept.
    task automatic run_op(input logic [W0-1:0] a, input logic [W1-1:0] b, input logic [1:0] md,
                          input logic [M-1:0] m, output logic [WP-1:0] res,
                          output logic [M-1:0] mo, output int lat);
        res = '0; mo = '0; lat = 0;
        bus.in_valid = 1'b1; bus.in0 = a; bus.in1 = b; bus.mode = md; bus.m_i = m;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && !bus.in_ready; i++) tick();
        tick();
        bus.in_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.out_valid) begin
                lat = i; res = bus.out0; mo = bus.m_o;
                break;
            end
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.in0 = '0; bus.in1 = '0; bus.mode = 2'b00; bus.m_i = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
            total++; if (bus.out0 !== '0) begin bad++; $display("FAIL reset_out0: got %h want 0", bus.out0); end
            total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", bus.err); end
            total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        end
        rst = 1'b0;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready: got %b want 1", bus.in_ready); end
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (bus.out_valid !== 1'b0 || bus.out0 !== '0 || bus.m_o !== '0) begin
                bad++; $display("FAIL idle_outputs: got v=%b out0=%h m=%h want 0", bus.out_valid, bus.out0, bus.m_o);
            end
        end
    endtask

    task automatic test_single();
        logic [WP-1:0] res; logic [M-1:0] mo; int lat;
        run_op(W0'(3), W1'(5), 2'b00, M'(32'hA5), res, mo, lat);
        total++; if (lat !== 7) begin bad++; $display("FAIL single_latency: got %0d want 7", lat); end
        total++; if (res !== WP'(15)) begin bad++; $display("FAIL single_out0: got %h want f", res); end
        total++; if (mo !== M'(32'hA5)) begin bad++; $display("FAIL single_m_o: got %h want a5", mo); end
    endtask

    task automatic test_all_ones();
        logic [WP-1:0] res, exp_full, exp_hi; logic [M-1:0] mo; int lat;
        exp_full = WP'(1) - (WP'(1) << 385);
        exp_hi   = (WP'(1) << 384) - WP'(2);
        run_op('1, '1, 2'b00, M'(1), res, mo, lat);
        total++; if (res !== exp_full || lat !== 7) begin bad++; $display("FAIL ones_full: got %h lat %0d want %h lat 7", res, lat, exp_full); end
        run_op('1, '1, 2'b10, M'(2), res, mo, lat);
        total++; if (res !== exp_hi || mo !== M'(2)) begin bad++; $display("FAIL ones_hi: got %h m %h want %h m 2", res, mo, exp_hi); end
        run_op('1, '1, 2'b01, M'(3), res, mo, lat);
        total++; if (res !== WP'(1) || mo !== M'(3)) begin bad++; $display("FAIL ones_lo: got %h m %h want 1 m 3", res, mo); end
    endtask

    task automatic test_back_to_back();
        logic [WP-1:0] exp_q [$];
        logic [M-1:0]  expm_q [$];
        logic [WP-1:0] prev_out0;
        logic [M-1:0]  prev_m;
        logic          stalled, accepted;
        int            sent, recv;
        sent = 0; recv = 0; stalled = 1'b0;
        bus.in_valid = 1'b0;
        for (int cyc = 0; cyc < 3000 && recv < 100; cyc++) begin
            if (!bus.in_valid && sent < 100) begin
                bus.in0 = rand_op(); bus.in1 = rand_op();
                bus.mode = 2'($urandom_range(0, 2)); bus.m_i = $urandom;
                bus.in_valid = 1'b1;
            end
            bus.out_ready = 1'($urandom_range(0, 1));
            #2;
            if (stalled) begin
                total++;
                if (bus.out_valid !== 1'b1 || bus.out0 !== prev_out0 || bus.m_o !== prev_m) begin
                    bad++; $display("FAIL stall_stable: got v=%b m=%h want v=1 m=%h", bus.out_valid, bus.m_o, prev_m);
                end
            end
            total++;
            if (bus.in_ready !== (bus.out_ready | ~bus.out_valid)) begin
                bad++; $display("FAIL in_ready_rule: got %b want %b", bus.in_ready, bus.out_ready | ~bus.out_valid);
            end
            if (bus.out_valid && bus.out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL stream_extra: got unexpected result m=%h want none", bus.m_o);
                end else begin
                    if (bus.out0 !== exp_q[0] || bus.m_o !== expm_q[0]) begin
                        bad++; $display("FAIL stream_result %0d: got %h m %h want %h m %h", recv, bus.out0, bus.m_o, exp_q[0], expm_q[0]);
                    end
                    void'(exp_q.pop_front()); void'(expm_q.pop_front());
                    recv++;
                end
            end
            stalled = bus.out_valid && !bus.out_ready;
            prev_out0 = bus.out0; prev_m = bus.m_o;
            accepted = bus.in_valid && bus.in_ready;
            if (accepted) begin
                exp_q.push_back(golden(bus.in0, bus.in1, bus.mode));
                expm_q.push_back(bus.m_i);
                sent++;
            end
            tick();
            if (accepted) bus.in_valid = 1'b0;
        end
        total++;
        if (recv != 100 || exp_q.size() != 0) begin
            bad++; $display("FAIL stream_count: got recv=%0d pending=%0d want 100 and 0", recv, exp_q.size());
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic test_err();
        logic [WP-1:0] res; logic [M-1:0] mo; int lat;
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL err_before: got %b want 0", bus.err); end
        run_op(W0'(2), W1'(2), 2'b11, M'(32'h3C), res, mo, lat);
        total++; if (res !== WP'(4) || mo !== M'(32'h3C)) begin bad++; $display("FAIL rsvd_out0: got %h m %h want 4 m 3c", res, mo); end
        total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL err_set: got %b want 1", bus.err); end
        for (int i = 0; i < 3; i++) tick();
        total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", bus.err); end
    endtask

    task automatic test_flush();
        logic [WP-1:0] res; logic [M-1:0] mo; int lat; logic seen;
        bus.out_ready = 1'b1; bus.mode = 2'b00;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1; bus.in0 = W0'(i + 1); bus.in1 = W1'(i + 10); bus.m_i = M'(i);
            tick();
        end
        bus.in_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL flush_err_clear: got %b want 0", bus.err); end
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.out_valid) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL flush_no_output: got out_valid seen=%b want 0", seen); end
        run_op(W0'(7), W1'(9), 2'b00, M'(32'h11), res, mo, lat);
        total++; if (res !== WP'(63) || mo !== M'(32'h11) || lat !== 7) begin
            bad++; $display("FAIL flush_new_op: got %h m %h lat %0d want 3f m 11 lat 7", res, mo, lat);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_ones();
        test_back_to_back();
        test_err();
        test_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
